// File: rtl/or1200_rf_pkg.sv
// Shared types and constants for the OR1200 multithreaded register-file writeback path.
package or1200_rf_pkg;

  localparam int RF_TW    = 3;
  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;
  localparam int RF_DEPTH = 4;

  localparam logic [RF_AW-1:0] R0 = '0;

  typedef struct packed {
    logic [RF_TW-1:0] thread;
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/or1200_rf_wb_fifo.sv
// Dual-push / dual-pop writeback queue with two head-peek outputs and synchronous flush.
// With OR1200_RF_WB_FWD_EN the storage and read pointer are exported for forwarding lookup.
module or1200_rf_wb_fifo
  import or1200_rf_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push_vld,
  input  wb_entry_t                i_push_dat,
  input  logic                     i_push2_vld,
  input  wb_entry_t                i_push2_dat,
  input  logic [1:0]               i_pop_cnt,
  output wb_entry_t                o_head_dat,
  output wb_entry_t                o_next_dat,
  output logic [$clog2(DEPTH):0]   o_count
`ifdef OR1200_RF_WB_FWD_EN
  ,
  output wb_entry_t                o_mem [DEPTH],
  output logic [$clog2(DEPTH)-1:0] o_rd_ptr
`endif
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW:0]     r_count;
  logic [PW-1:0]   w_wr_idx2;

  // Lane 2 lands right behind lane 1, or in lane 1's slot when lane 1 is idle.
  assign w_wr_idx2 = r_wr_ptr + PW'(i_push_vld);

  always_ff @(posedge clk) begin
    if (i_push_vld)  r_mem[r_wr_ptr]  <= i_push_dat;
    if (i_push2_vld) r_mem[w_wr_idx2] <= i_push2_dat;
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(i_push_vld) + PW'(i_push2_vld);
      r_rd_ptr <= r_rd_ptr + PW'(i_pop_cnt);
      r_count  <= r_count + (PW+1)'(i_push_vld) + (PW+1)'(i_push2_vld)
                  - (PW+1)'(i_pop_cnt);
    end
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_next_dat = r_mem[r_rd_ptr + PW'(1)];
  assign o_count    = r_count;

`ifdef OR1200_RF_WB_FWD_EN
  assign o_mem    = r_mem;
  assign o_rd_ptr = r_rd_ptr;
`endif

endmodule

// File: rtl/or1200_rf_wb_ctrl.sv
// Writeback controller: queues lane results and drives both RF write ports, pairing same-thread writes.
// Optional forwarding lookup over pending writes is enabled by defining OR1200_RF_WB_FWD_EN.
module or1200_rf_wb_ctrl
  import or1200_rf_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH,
  parameter int AW    = RF_AW,
  parameter int DW    = RF_DW,
  parameter int TW    = RF_TW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   res_valid,
  input  logic [TW-1:0]          res_thread,
  input  logic [AW-1:0]          res_addr,
  input  logic [DW-1:0]          res_data,
  input  logic                   res_valid2,
  input  logic [TW-1:0]          res_thread2,
  input  logic [AW-1:0]          res_addr2,
  input  logic [DW-1:0]          res_data2,
  output logic                   res_ready,
  input  logic                   wb_freeze,
  input  logic                   flushpipe,
  output logic                   we,
  output logic [AW-1:0]          addrw,
  output logic [DW-1:0]          dataw,
  output logic                   we2,
  output logic [AW-1:0]          addrw2,
  output logic [DW-1:0]          dataw2,
  output logic [TW-1:0]          current_thread_write,
  output logic [$clog2(DEPTH):0] pending,
  input  logic [TW-1:0]          fwd_thread,
  input  logic [AW-1:0]          fwd_addr,
  output logic                   fwd_hit,
  output logic [DW-1:0]          fwd_data
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t   w_in1, w_in2, w_head, w_next;
  logic        w_push1, w_push2;
  logic        w_issue, w_pair;
  logic [1:0]  w_pop_cnt;

  logic          r_we, r_we2;
  logic [AW-1:0] r_addrw, r_addrw2;
  logic [DW-1:0] r_dataw, r_dataw2;
  logic [TW-1:0] r_thread;

  assign w_in1 = '{thread: res_thread,  addr: res_addr,  data: res_data};
  assign w_in2 = '{thread: res_thread2, addr: res_addr2, data: res_data2};

  // Admission depends only on registered occupancy, so both lanes always fit.
  assign res_ready = (pending <= (PW+1)'(DEPTH - 2));
  assign w_push1   = res_valid  & res_ready & ~flushpipe & (res_addr  != R0);
  assign w_push2   = res_valid2 & res_ready & ~flushpipe & (res_addr2 != R0);

  assign w_issue   = ~wb_freeze & ~flushpipe & (pending != '0);
  assign w_pair    = w_issue & (pending >= (PW+1)'(2))
                   & (w_next.thread == w_head.thread)
                   & (w_next.addr   != w_head.addr);
  assign w_pop_cnt = w_pair ? 2'd2 : (w_issue ? 2'd1 : 2'd0);

`ifdef OR1200_RF_WB_FWD_EN
  wb_entry_t     w_mem [DEPTH];
  logic [PW-1:0] w_rd_ptr;
  logic [PW-1:0] w_idx;
`endif

  or1200_rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (flushpipe),
    .i_push_vld  (w_push1),
    .i_push_dat  (w_in1),
    .i_push2_vld (w_push2),
    .i_push2_dat (w_in2),
    .i_pop_cnt   (w_pop_cnt),
    .o_head_dat  (w_head),
    .o_next_dat  (w_next),
    .o_count     (pending)
`ifdef OR1200_RF_WB_FWD_EN
    ,
    .o_mem       (w_mem),
    .o_rd_ptr    (w_rd_ptr)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_we2    <= 1'b0;
      r_addrw  <= '0;
      r_addrw2 <= '0;
      r_dataw  <= '0;
      r_dataw2 <= '0;
      r_thread <= '0;
    end else if (flushpipe) begin
      r_we  <= 1'b0;
      r_we2 <= 1'b0;
    end else if (!wb_freeze) begin
      r_we  <= w_issue;
      r_we2 <= w_pair;
      if (w_issue) begin
        r_addrw  <= w_head.addr;
        r_dataw  <= w_head.data;
        r_thread <= w_head.thread;
      end
      if (w_pair) begin
        r_addrw2 <= w_next.addr;
        r_dataw2 <= w_next.data;
      end
    end
  end

  assign we                   = r_we;
  assign we2                  = r_we2;
  assign addrw                = r_addrw;
  assign addrw2               = r_addrw2;
  assign dataw                = r_dataw;
  assign dataw2               = r_dataw2;
  assign current_thread_write = r_thread;

`ifdef OR1200_RF_WB_FWD_EN
  // Scan oldest to youngest so the last match seen is the youngest write.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    w_idx    = '0;
    if (fwd_addr != R0) begin
      if (r_we && r_thread == fwd_thread && r_addrw == fwd_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = r_dataw;
      end
      if (r_we2 && r_thread == fwd_thread && r_addrw2 == fwd_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = r_dataw2;
      end
      for (int i = 0; i < DEPTH; i++) begin
        w_idx = w_rd_ptr + PW'(i);
        if (((PW+1)'(i) < pending) && (w_mem[w_idx].thread == fwd_thread)
            && (w_mem[w_idx].addr == fwd_addr)) begin
          fwd_hit  = 1'b1;
          fwd_data = w_mem[w_idx].data;
        end
      end
    end
  end
`else
  logic w_fwd_unused;
  assign w_fwd_unused = ^{fwd_thread, fwd_addr};
  assign fwd_hit      = 1'b0;
  assign fwd_data     = '0;
`endif

endmodule
